// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with a valid/ready handshake, synchronous flush and an
// optional skid entry, so stalls travel upstream as back-pressure.
module pipe_stage_hs #(
  parameter int unsigned      WIDTH   = 32,
  parameter bit               SKID    = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       level_o
);

  logic in_xfer, out_xfer;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  generate
    if (SKID) begin : g_skid
      typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

      state_e           state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             ready_q;

      // Flush wins over any transfer; a coincident output beat was already sampled downstream.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
          state_d = EMPTY;
          main_d  = RST_VAL;
        end else begin
          case (state_q)
            EMPTY: if (in_xfer) begin
              main_d  = data_i;
              state_d = ONE;
            end
            ONE: begin
              if (in_xfer && out_xfer) begin
                main_d = data_i;
              end else if (in_xfer) begin
                skid_d  = data_i;
                state_d = TWO;
              end else if (out_xfer) begin
                state_d = EMPTY;
              end
            end
            TWO: if (out_xfer) begin
              main_d  = skid_q;
              state_d = ONE;
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      // Ready is precomputed from next state so it leaves a flop with no input-side path.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          state_q <= EMPTY;
          main_q  <= RST_VAL;
          skid_q  <= '0;
          ready_q <= 1'b1;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          ready_q <= (state_d != TWO);
        end
      end

      assign in_ready_o  = ready_q;
      assign out_valid_o = (state_q != EMPTY);
      assign data_o      = main_q;
      assign level_o     = state_q;
    end else begin : g_single
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] main_q, main_d;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush_i) begin
          valid_d = 1'b0;
          main_d  = RST_VAL;
        end else if (in_xfer) begin
          valid_d = 1'b1;
          main_d  = data_i;
        end else if (out_xfer) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          valid_q <= 1'b0;
          main_q  <= RST_VAL;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign in_ready_o  = out_ready_i | ~valid_q;
      assign out_valid_o = valid_q;
      assign data_o      = main_q;
      assign level_o     = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three instances (skid/32b, single/32b, skid/8b) share
// one stimulus and are each checked every cycle against a small FIFO model.
module tb_pipe_stage_hs;

  localparam int S32 = 0, N32 = 1, S8 = 2;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] din;
  logic [2:0]  ov, rd;
  logic [1:0]  lv [3];
  logic [31:0] dq [3];
  logic [7:0]  d8;

  int checks = 0, failures = 0;

  // Model: each stage is a FIFO of capacity 2 (skid) or 1, plus the last shown value.
  bit          mskid [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] mrst  [3] = '{32'h0, 32'h0, 32'h5A};
  logic [31:0] mq    [3][2];
  int          mn    [3] = '{0, 0, 0};
  logic [31:0] md    [3] = '{32'h0, 32'h0, 32'h5A};

  pipe_stage_hs #(.WIDTH(32), .SKID(1'b1), .RST_VAL(32'h0)) u_s32 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rd[S32]), .data_i(din), .out_valid_o(ov[S32]),
    .out_ready_i(out_ready), .data_o(dq[S32]), .level_o(lv[S32]));

  pipe_stage_hs #(.WIDTH(32), .SKID(1'b0), .RST_VAL(32'h0)) u_n32 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rd[N32]), .data_i(din), .out_valid_o(ov[N32]),
    .out_ready_i(out_ready), .data_o(dq[N32]), .level_o(lv[N32]));

  pipe_stage_hs #(.WIDTH(8), .SKID(1'b1), .RST_VAL(8'h5A)) u_s8 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rd[S8]), .data_i(din[7:0]), .out_valid_o(ov[S8]),
    .out_ready_i(out_ready), .data_o(d8), .level_o(lv[S8]));

  assign dq[S8] = {24'h0, d8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mready(int i);
    return mskid[i] ? (mn[i] < 2) : (mn[i] == 0 || out_ready);
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit ix, ox;
      ix = in_valid && mready(i);
      ox = (mn[i] > 0) && out_ready;
      if (!rst_n || flush) begin
        mn[i] = 0;
        md[i] = mrst[i];
      end else begin
        if (ox) begin
          mq[i][0] = mq[i][1];
          mn[i]--;
        end
        if (ix) begin
          mq[i][mn[i]] = din & mmask[i];
          mn[i]++;
        end
        if (mn[i] > 0) md[i] = mq[i][0];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m%0d_valid", i), {31'h0, ov[i]}, {31'h0, mn[i] > 0});
      chk($sformatf("m%0d_level", i), {30'h0, lv[i]}, mn[i]);
      chk($sformatf("m%0d_data", i), dq[i], md[i]);
      chk($sformatf("m%0d_ready", i), {31'h0, rd[i]}, {31'h0, mready(i)});
    end
  endtask

  // One clock: model advances on the edge, DUTs compared just after it, inputs change at +2.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1 compare_all();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;

    // Reset held two cycles
    tick(); tick();
    chk("rst_data", dq[S32], 32'h0);
    chk("rst_valid", {31'h0, ov[S32]}, 32'h0);
    chk("rst_level", {30'h0, lv[S32]}, 32'h0);
    chk("rst_ready", {31'h0, rd[S32]}, 32'h1);
    chk("rst_data8", dq[S8], 32'h5A);
    rst_n = 1'b1;

    // Full-throughput stream
    in_valid = 1'b1; out_ready = 1'b1;
    din = 32'h1; tick(); chk("str1", dq[S32], 32'h1);
    din = 32'h2; tick(); chk("str2", dq[S32], 32'h2);
    din = 32'h3; tick(); chk("str3", dq[S32], 32'h3);
    chk("str_ready", {31'h0, rd[S32]}, 32'h1);
    chk("str_level", {30'h0, lv[S32]}, 32'h1);

    // Back-pressure fill and drain
    din = 32'hA; tick(); chk("bp_a", dq[S32], 32'hA);
    out_ready = 1'b0;
    din = 32'hB; tick(); chk("bp_lvl2", {30'h0, lv[S32]}, 32'h2);
    chk("bp_nrdy", {31'h0, rd[S32]}, 32'h0);
    din = 32'hC; tick(); chk("bp_hold", dq[S32], 32'hA);
    chk("bp_hold_lvl", {30'h0, lv[S32]}, 32'h2);
    out_ready = 1'b1;
    tick(); chk("bp_out_b", dq[S32], 32'hB);
    chk("bp_lvl1", {30'h0, lv[S32]}, 32'h1);
    tick(); chk("bp_out_c", dq[S32], 32'hC);
    in_valid = 1'b0;
    tick(); chk("bp_empty", {31'h0, ov[S32]}, 32'h0);
    chk("bp_keep", dq[S32], 32'hC);

    // Flush with coincident in/out transfers at level 2
    out_ready = 1'b0; in_valid = 1'b1;
    din = 32'h5; tick();
    din = 32'h6; tick(); chk("fl_lvl2", {30'h0, lv[S32]}, 32'h2);
    flush = 1'b1; din = 32'h7; out_ready = 1'b1;
    tick();
    chk("fl_valid", {31'h0, ov[S32]}, 32'h0);
    chk("fl_level", {30'h0, lv[S32]}, 32'h0);
    chk("fl_data", dq[S32], 32'h0);
    chk("fl_data8", dq[S8], 32'h5A);
    flush = 1'b0; in_valid = 1'b0;
    tick(); chk("fl_no7", {31'h0, ov[S32]}, 32'h0);

    // Single-entry: combinational ready
    in_valid = 1'b1; out_ready = 1'b1; din = 32'h11;
    tick(); chk("n_d11", dq[N32], 32'h11);
    chk("n_v", {31'h0, ov[N32]}, 32'h1);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("n_rdy0", {31'h0, rd[N32]}, 32'h0);
    out_ready = 1'b1;
    #1 chk("n_rdy1", {31'h0, rd[N32]}, 32'h1);
    in_valid = 1'b1; din = 32'h22;
    tick(); chk("n_d22", dq[N32], 32'h22);
    chk("n_lvl", {30'h0, lv[N32]}, 32'h1);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("n_rdy0b", {31'h0, rd[N32]}, 32'h0);
    tick(); chk("n_hold", dq[N32], 32'h22);

    // Async reset mid-stream at level 2
    flush = 1'b1; tick(); flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    din = 32'h81; tick();
    din = 32'h82; tick(); chk("ar_lvl2", {30'h0, lv[S32]}, 32'h2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'h0, ov[S32]}, 32'h0);
    chk("ar_level", {30'h0, lv[S32]}, 32'h0);
    chk("ar_data", dq[S32], 32'h0);
    chk("ar_ready", {31'h0, rd[S32]}, 32'h1);
    chk("ar_data8", dq[S8], 32'h5A);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; din = 32'h9;
    tick(); chk("ar_first", dq[S32], 32'h9);
    chk("ar_first_lvl", {30'h0, lv[S32]}, 32'h1);
    in_valid = 1'b0;
    tick(); chk("ar_alone", {30'h0, lv[S32]}, 32'h1);
    out_ready = 1'b1;
    tick(); chk("ar_drain", {31'h0, ov[S32]}, 32'h0);

    // Random stress
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(99) < 70);
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(99) < 3);
      din       = $urandom;
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
